// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CW-1:0]    CNT_DONE = CW'(WIDTH);

  typedef enum logic [1:0] {
    FREE,
    BYZERO,
    ON,
    END
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // {partial remainder, dividend/quotient}; one spare MSB keeps the shifted remainder
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   quot_raw;
  logic [WIDTH-1:0]   rem_raw;

  // Operand magnitudes, one restoring iteration and the raw quotient/remainder
  always_comb begin
    dividend_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + ONE) : opdata1_i;
    divisor_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + ONE) : opdata2_i;
    shifted      = {work_q[2*WIDTH-1:0], 1'b0};
    // Extra MSB acts as the borrow: set means the trial went negative
    trial        = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor_q};
    quot_raw     = work_q[WIDTH-1:0];
    rem_raw      = work_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    unique case (state_q)
      FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d    = ON;
            cnt_d      = '0;
            work_d     = {{(WIDTH+1){1'b0}}, dividend_mag};
            divisor_d  = divisor_mag;
            neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
          end
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          state_d  = END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == CNT_DONE) begin
          state_d  = END;
          result_d = {neg_rem_q  ? (~rem_raw + ONE)  : rem_raw,
                      neg_quot_q ? (~quot_raw + ONE) : quot_raw};
          ready_d  = 1'b1;
        end else begin
          if (!trial[WIDTH+1]) begin
            work_d = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
          end else begin
            work_d = shifted;
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
      END: begin
        if (annul_i || !start_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d  = FREE;
        cnt_d    = '0;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
